// File: rtl/cordic_pkg.sv
// cordic_pkg: shared FSM states, arctangent table generator and gain constant for the vectoring CORDIC.
package cordic_pkg;
    typedef enum logic [1:0] {IDLE, ITERATE, DONE} state_t;
    // Reciprocal of the CORDIC gain (1/K ~ 0.60725) in Q0.16, for downstream magnitude compensation.
    localparam int CORDIC_GAIN_Q = 39797;
    function automatic int atan_lut(int bw, int i);
        return $rtoi($atan(2.0 ** (-i)) * (2.0 ** (bw - 1)) / 3.141592653589793 + 0.5);
    endfunction
endpackage

// File: rtl/cordic_vector_lane.sv
// cordic_vector_lane: one channel's pre-rotation, micro-rotation registers, zero flag and output registers.
module cordic_vector_lane
    import cordic_pkg::*;
#(
    parameter int BW = 24,
    parameter int N_ITER = 24,
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic          last,
    input  logic [CW-1:0] i,
    input  logic [BW-1:0] x_in,
    input  logic [BW-1:0] y_in,
    output logic [BW-1:0] phi_out,
    output logic [BW+1:0] mag_out,
    output logic          zero_out
);
    localparam int W = BW + 2;
    localparam logic [BW-1:0] QTR = BW'(1) << (BW - 2);
    logic signed [W-1:0] xs, ys, x0, y0, x, y, xn, yn;
    logic [BW-1:0] p0, p, pn;
    logic z;
    logic [BW-1:0] atan_tab [2**CW];
    for (genvar k = 0; k < 2**CW; k++) begin : g_atan
        localparam logic [BW-1:0] A = k < N_ITER ? BW'(atan_lut(BW, k)) : '0;
        assign atan_tab[k] = A;
    end
    // Left-half inputs are turned by +/-90 degrees so the micro-rotations only need to cover +/-99 degrees.
    always_comb begin
        xs = W'($signed(x_in));
        ys = W'($signed(y_in));
        x0 = xs[W-1] ? (ys[W-1] ? -ys : ys) : xs;
        y0 = xs[W-1] ? (ys[W-1] ? xs : -xs) : ys;
        p0 = xs[W-1] ? (ys[W-1] ? -QTR : QTR) : '0;
        xn = y[W-1] ? x - (y >>> i) : x + (y >>> i);
        yn = y[W-1] ? y + (x >>> i) : y - (x >>> i);
        pn = y[W-1] ? p - atan_tab[i] : p + atan_tab[i];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x        <= '0;
            y        <= '0;
            p        <= '0;
            z        <= 1'b0;
            phi_out  <= '0;
            mag_out  <= '0;
            zero_out <= 1'b0;
        end else begin
            if (load) begin
                x <= x0;
                y <= y0;
                p <= p0;
                z <= x_in == '0 && y_in == '0;
            end else if (step) begin
                x <= xn;
                y <= yn;
                p <= pn;
            end
            if (last) begin
                phi_out  <= z ? '0 : pn;
                mag_out  <= z ? '0 : xn;
                zero_out <= z;
            end
        end
    end
endmodule

// File: rtl/cordic_vector_mc.sv
// cordic_vector_mc: multi-channel iterative vectoring CORDIC (x,y) -> (phase, magnitude) with a shared FSM.
module cordic_vector_mc
    import cordic_pkg::*;
#(
    parameter int BIT_WIDTH = 24,
    parameter int N_CH = 2,
    parameter int N_ITER = 24
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    output logic                          ready_o,
    input  logic [N_CH*BIT_WIDTH-1:0]     x_i,
    input  logic [N_CH*BIT_WIDTH-1:0]     y_i,
    output logic [N_CH*BIT_WIDTH-1:0]     phi_o,
    output logic [N_CH*(BIT_WIDTH+2)-1:0] mag_o,
    output logic [N_CH-1:0]               zero_o,
    output logic                          done_o
);
    localparam int CW = $clog2(N_ITER) + 1;
    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic load, step, last;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= load ? '0 : step ? cnt + CW'(1) : cnt;
        end
    end
    // DONE also accepts a new start, giving back-to-back conversions every N_ITER+1 cycles.
    always_comb begin
        ready_o = state != ITERATE;
        done_o  = state == DONE;
        load    = ready_o && start_i;
        step    = state == ITERATE;
        last    = step && cnt == CW'(N_ITER - 1);
        nxt     = load ? ITERATE : last ? DONE : step ? ITERATE : IDLE;
    end
    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        cordic_vector_lane #(.BW(BIT_WIDTH), .N_ITER(N_ITER), .CW(CW)) u_lane (
            .clk      (clk_i),
            .rst      (rst_i),
            .load     (load),
            .step     (step),
            .last     (last),
            .i        (cnt),
            .x_in     (x_i[c*BIT_WIDTH +: BIT_WIDTH]),
            .y_in     (y_i[c*BIT_WIDTH +: BIT_WIDTH]),
            .phi_out  (phi_o[c*BIT_WIDTH +: BIT_WIDTH]),
            .mag_out  (mag_o[c*(BIT_WIDTH+2) +: BIT_WIDTH+2]),
            .zero_out (zero_o[c])
        );
    end
endmodule

// File: doc/cordic_vector_mc.md
Name: cordic_vector_mc

Overview:
Multi-channel, full-circle iterative CORDIC in vectoring mode. Converts N_CH signed (x, y) pairs, typically quadrature demodulator I/Q, into phase and magnitude. Successor to the single-channel phase-only CORDIC FSR:
- adds quadrant pre-rotation (±π range)
- adds magnitude output and per-channel zero detection
- parametrises iteration count
- adds a ready/start handshake with back-to-back acceptance

Sits between the lock-in demodulators and the phase-unwrapping logic.

Parameters:
BIT_WIDTH, 24, width of signed x/y inputs and of phase output
N_CH, 2, number of parallel channels sharing one FSM
N_ITER, 24, micro-rotations per conversion (1..BIT_WIDTH); sets counter width $clog2(N_ITER)+1

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
start_i  in  1  request conversion; accepted only when ready_o=1
ready_o  out  1  block can accept start_i this cycle
x_i  in  N_CH*BIT_WIDTH  signed x per channel; channel c at [c*BIT_WIDTH +: BIT_WIDTH]
y_i  in  N_CH*BIT_WIDTH  signed y per channel, same packing
phi_o  out  N_CH*BIT_WIDTH  signed binary angle per channel: 2^(BIT_WIDTH-1) ≙ π
mag_o  out  N_CH*(BIT_WIDTH+2)  unsigned magnitude × CORDIC gain K≈1.6468 (uncompensated)
zero_o  out  N_CH  channel input was (0,0)
done_o  out  1  one-cycle pulse: phi_o/mag_o/zero_o updated this cycle

Behaviour:
Reset:
- FSM to IDLE; phi_o, mag_o, zero_o, done_o = 0; ready_o=1.
- Reset mid-ITERATE aborts with no done_o pulse.

States:
- IDLE: ready_o=1.
- ITERATE: ready_o=0; counter i runs 0..N_ITER-1.
- DONE: done_o=1, ready_o=1.

Transitions:
- IDLE→ITERATE on start_i.
- ITERATE→DONE after the micro-rotation with i=N_ITER-1.
- DONE→ITERATE if start_i, else DONE→IDLE.

Handshake:
- On the accept edge, x_i/y_i of all channels are captured.
- Inputs are don't-care afterwards.
- start_i while ready_o=0 is ignored, not queued.

Latency and throughput:
- Accept at edge t → done_o high in cycle t+N_ITER+1.
- Back-to-back throughput is one conversion per N_ITER+1 cycles.

Outputs:
- Registered; they change only in the DONE cycle and hold otherwise.

Datapath per channel:
- Internal width BIT_WIDTH+2, sign-extended, so growth of ≤K·√2 never overflows.
- The input -2^(BIT_WIDTH-1) must work on both axes.

Pre-rotation, applied at load:
- x<0, y≥0: (x,y)←(y,−x), phi←+2^(BIT_WIDTH-2).
- x<0, y<0: (x,y)←(−y,x), phi←−2^(BIT_WIDTH-2).
- Else no change, phi←0.

Micro-rotation i:
- If y≥0: x+=y>>>i, y−=x>>>i, phi+=ATAN[i].
- Else: the opposite signs.
- Shifts are arithmetic.
- phi accumulates modulo 2^BIT_WIDTH, so ±π wraps.

Result:
- mag_o = final x (always ≥0).
- Truncation error: phase ≤ N_ITER+2 LSB for N_ITER=BIT_WIDTH, modular.
- Magnitude ≤ N_ITER/2+2 LSB relative to K·|v|.

Zero input:
- (0,0) detected at load.
- In DONE: zero_o[c]=1, phi_o=0, mag_o=0, overriding the datapath.

Channel independence:
- All channels run in lock-step.
- One channel's value never affects another's.

Decomposition:
Package cordic_pkg:
- state enum (IDLE, ITERATE, DONE)
- function atan_lut(BIT_WIDTH, N_ITER) returning ATAN[i] = round(atan(2^-i)·2^(BIT_WIDTH-1)/π), evaluated at elaboration
- constant CORDIC_GAIN_Q for downstream compensation

Sub-module cordic_vector_lane:
- one channel's pre-rotation, micro-rotation registers and zero flag
- driven by load/step/i from the shared FSM in the top
- generated N_CH times

Test Plan:
Bench configuration: BIT_WIDTH=16, N_ITER=16, N_CH=2; π=32768.
1. ch0 (1000,1000), ch1 (0,1000), single start → done_o exactly 17 cycles after accept; phi0≈8192±18, mag0≈2329±10; phi1≈16384±18, mag1≈1647±10.
2. ch0 (−1000,−1000), ch1 (−1000,0) → phi0≈−24576±18; phi1 within 18 LSB of ±32768 modulo 2^16; mag1≈1647±10.
3. ch0 (−32768,−32768), ch1 (32767,−32768) → no overflow; phi0≈−24576, phi1≈−8192; mag≈76313±20 for both.
4. ch0 (0,0), ch1 (5,−3) → zero_o=2'b01, phi0=0, mag0=0; ch1 phase within tolerance.
5. Hold start_i high continuously → accepts in IDLE and every DONE cycle; done_o every 17 cycles. A start pulse mid-ITERATE is ignored, with no extra done_o.
6. Assert rst_i at iteration 8 → outputs 0, no done_o. After release ready_o=1, and a fresh conversion gives correct results.
